fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle-issue AVR core. Holds the program counter, drives a synchronous program memory and registers the returned 16-bit word into an instruction register. The word feeds the decode stage: bits [15:10] go to the control ROM opcode input, and the register and immediate fields are pre-extracted for the register file and ALU B-mux. Supports decode/execute stall and taken-branch redirect with squash of the wrong-path word.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage and the decode stage that consumes its fields.
package fetch_unit_pkg;

  localparam int PC_WIDTH_DEF     = 10;
  localparam int RESET_VECTOR_DEF = 0;

  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int IMM8_W   = 8;

  // All-zero word decodes as a nop with register write disabled.
  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, synchronous program-memory interface and
// instruction register with stall hold and taken-branch redirect/squash.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_en,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                stall,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    rr,
  output logic [IMM8_W-1:0]   imm8
);

  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_VECTOR);

  // Word-address increment, wrapping modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(1);
  endfunction

  logic [PC_WIDTH-1:0] fetch_pc_p0;
  logic [PC_WIDTH-1:0] mem_pc_p1;
  logic                vld_p1;
  logic [INSTR_W-1:0]  instr_p2;
  logic [PC_WIDTH-1:0] instr_pc_p2;
  logic                vld_p2;

  // Memory address/enable: a redirect reads the target immediately, otherwise the
  // enable drops on stall so the memory keeps presenting the held word.
  always_comb begin
    imem_addr = branch_en ? branch_target : fetch_pc_p0;
    imem_en   = branch_en | ~stall;
  end

  // p0 -> p1: advance fetch address and track which word the memory is returning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_p0 <= RST_PC;
      mem_pc_p1   <= RST_PC;
      vld_p1      <= 1'b0;
    end else if (branch_en) begin
      fetch_pc_p0 <= pc_inc(branch_target);
      mem_pc_p1   <= branch_target;
      vld_p1      <= 1'b1;
    end else if (!stall) begin
      fetch_pc_p0 <= pc_inc(fetch_pc_p0);
      mem_pc_p1   <= fetch_pc_p0;
      vld_p1      <= 1'b1;
    end
  end

  // p1 -> p2: capture the memory word; a redirect squashes the wrong-path word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p2    <= NOP;
      instr_pc_p2 <= RST_PC;
      vld_p2      <= 1'b0;
    end else if (branch_en) begin
      instr_p2    <= NOP;
      vld_p2      <= 1'b0;
    end else if (!stall) begin
      instr_p2    <= vld_p1 ? imem_data : NOP;
      instr_pc_p2 <= mem_pc_p1;
      vld_p2      <= vld_p1;
    end
  end

  // Decode fields are plain slices of the instruction register.
  always_comb begin
    instr       = instr_p2;
    instr_valid = vld_p2;
    instr_pc    = instr_pc_p2;
    opcode      = instr_p2[15:10];
    rd          = instr_p2[8:4];
    rr          = {instr_p2[9], instr_p2[3:0]};
    imm8        = {instr_p2[11:8], instr_p2[3:0]};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, branch, branch+stall,
// PC wrap with a narrow PC and asynchronous mid-run reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Default-width instance
  logic        rst_n, stall, branch_en;
  logic [9:0]  branch_target, imem_addr, instr_pc;
  logic        imem_en, instr_valid;
  logic [15:0] imem_data, instr;
  logic [5:0]  opcode;
  logic [4:0]  rd, rr;
  logic [7:0]  imm8;
  logic [15:0] mem10 [1024];

  // Narrow-PC instance, reset vector near the top of the space
  logic        rst4_n, stall4, branch4_en;
  logic [3:0]  branch4_target, imem4_addr, instr4_pc;
  logic        imem4_en, instr4_valid;
  logic [15:0] imem4_data, instr4;
  logic [5:0]  opcode4;
  logic [4:0]  rd4, rr4;
  logic [7:0]  imm84;
  logic [15:0] mem4 [16];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_en(imem_en),
    .imem_data(imem_data), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .instr(instr), .instr_valid(instr_valid),
    .instr_pc(instr_pc), .opcode(opcode), .rd(rd), .rr(rr), .imm8(imm8)
  );

  fetch_unit #(.PC_WIDTH(4), .RESET_VECTOR(13)) dut4 (
    .clk(clk), .rst_n(rst4_n), .imem_addr(imem4_addr), .imem_en(imem4_en),
    .imem_data(imem4_data), .stall(stall4), .branch_en(branch4_en),
    .branch_target(branch4_target), .instr(instr4), .instr_valid(instr4_valid),
    .instr_pc(instr4_pc), .opcode(opcode4), .rd(rd4), .rr(rr4), .imm8(imm84)
  );

  always #5 clk = ~clk;

  // Synchronous program memories with read enable, 1-cycle latency
  always @(posedge clk) if (imem_en) imem_data <= mem10[imem_addr];
  always @(posedge clk) if (imem4_en) imem4_data <= mem4[imem4_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mem10[0] = 16'hE0A5;
    rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL rst_instr got=%h exp=0000", instr); end
    checks++; if (imem_addr !== 10'd0) begin failures++; $display("FAIL rst_addr got=%h exp=000", imem_addr); end
    checks++; if (imem_en !== 1'b1) begin failures++; $display("FAIL rst_en got=%b exp=1", imem_en); end
    checks++; if (instr_pc !== 10'd0) begin failures++; $display("FAIL rst_pc got=%h exp=000", instr_pc); end
    rst_n = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL edge1_valid got=%b exp=0", instr_valid); end
    tick();
    checks++; if (instr !== 16'hE0A5) begin failures++; $display("FAIL edge2_instr got=%h exp=e0a5", instr); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL edge2_valid got=%b exp=1", instr_valid); end
    checks++; if (opcode !== 6'b111000) begin failures++; $display("FAIL edge2_opcode got=%b exp=111000", opcode); end
    checks++; if (rd !== 5'b01010) begin failures++; $display("FAIL edge2_rd got=%b exp=01010", rd); end
    checks++; if (rr !== 5'b00101) begin failures++; $display("FAIL edge2_rr got=%b exp=00101", rr); end
    checks++; if (imm8 !== 8'h05) begin failures++; $display("FAIL edge2_imm8 got=%h exp=05", imm8); end
    checks++; if (instr_pc !== 10'd0) begin failures++; $display("FAIL edge2_pc got=%h exp=000", instr_pc); end
  endtask

  task automatic test_stream();
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h2001; exp_w[1] = 16'h2012; exp_w[2] = 16'h2023; exp_w[3] = 16'h2034;
    for (int i = 0; i < 4; i++) mem10[i] = exp_w[i];
    do_reset();
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (instr_pc !== 10'(i)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, instr_pc, 10'(i)); end
      checks++; if (instr !== exp_w[i]) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, instr, exp_w[i]); end
      checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, instr_valid); end
      tick();
    end
  endtask

  // Leaves the DUT showing instr_pc=3 for the branch test.
  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    checks++; if (instr_pc !== 10'd1) begin failures++; $display("FAIL stall_pre_pc got=%h exp=001", instr_pc); end
    stall = 1'b1;
    #1;
    checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL stall_en got=%b exp=0", imem_en); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr !== 16'h2012) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=2012", i, instr); end
      checks++; if (instr_pc !== 10'd1) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=001", i, instr_pc); end
      checks++; if (imem_addr !== 10'd3) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=003", i, imem_addr); end
      checks++; if (imem_en !== 1'b0) begin failures++; $display("FAIL stall_en[%0d] got=%b exp=0", i, imem_en); end
    end
    stall = 1'b0;
    tick();
    checks++; if (instr_pc !== 10'd2) begin failures++; $display("FAIL unstall_pc2 got=%h exp=002", instr_pc); end
    checks++; if (instr !== 16'h2023) begin failures++; $display("FAIL unstall_instr2 got=%h exp=2023", instr); end
    tick();
    checks++; if (instr_pc !== 10'd3) begin failures++; $display("FAIL unstall_pc3 got=%h exp=003", instr_pc); end
    checks++; if (instr !== 16'h2034) begin failures++; $display("FAIL unstall_instr3 got=%h exp=2034", instr); end
  endtask

  task automatic test_branch();
    branch_en = 1'b1; branch_target = 10'h020;
    #1;
    checks++; if (imem_addr !== 10'h020) begin failures++; $display("FAIL br_addr got=%h exp=020", imem_addr); end
    tick();
    branch_en = 1'b0; branch_target = '0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL br_squash_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL br_squash_instr got=%h exp=0000", instr); end
    checks++; if (opcode !== 6'd0) begin failures++; $display("FAIL br_squash_opcode got=%h exp=00", opcode); end
    tick();
    checks++; if (instr !== 16'h4020) begin failures++; $display("FAIL br_instr got=%h exp=4020", instr); end
    checks++; if (instr_pc !== 10'h020) begin failures++; $display("FAIL br_pc got=%h exp=020", instr_pc); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL br_valid got=%b exp=1", instr_valid); end
    tick();
    checks++; if (instr_pc !== 10'h021) begin failures++; $display("FAIL br_next_pc got=%h exp=021", instr_pc); end
    checks++; if (instr !== 16'h4021) begin failures++; $display("FAIL br_next_instr got=%h exp=4021", instr); end
  endtask

  task automatic test_branch_stall();
    branch_en = 1'b1; stall = 1'b1; branch_target = 10'h010;
    #1;
    checks++; if (imem_en !== 1'b1) begin failures++; $display("FAIL brst_en got=%b exp=1", imem_en); end
    tick();
    branch_en = 1'b0; stall = 1'b0; branch_target = '0;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL brst_squash_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 16'h0000) begin failures++; $display("FAIL brst_squash_instr got=%h exp=0000", instr); end
    tick();
    checks++; if (instr_pc !== 10'h010) begin failures++; $display("FAIL brst_pc got=%h exp=010", instr_pc); end
    checks++; if (instr !== 16'h4010) begin failures++; $display("FAIL brst_instr got=%h exp=4010", instr); end
    tick();
    checks++; if (instr_pc !== 10'h011) begin failures++; $display("FAIL brst_next_pc got=%h exp=011", instr_pc); end
  endtask

  task automatic test_wrap_async_reset();
    logic [3:0] exp_pc [5];
    exp_pc[0] = 4'd13; exp_pc[1] = 4'd14; exp_pc[2] = 4'd15; exp_pc[3] = 4'd0; exp_pc[4] = 4'd1;
    checks++; if (imem4_addr !== 4'd13) begin failures++; $display("FAIL w_rst_addr got=%h exp=d", imem4_addr); end
    checks++; if (instr4_pc !== 4'd13) begin failures++; $display("FAIL w_rst_pc got=%h exp=d", instr4_pc); end
    rst4_n = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr4_pc !== exp_pc[i]) begin failures++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, instr4_pc, exp_pc[i]); end
      checks++; if (instr4 !== (16'h5000 | 16'(exp_pc[i]))) begin failures++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", i, instr4, 16'h5000 | 16'(exp_pc[i])); end
      checks++; if (instr4_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid[%0d] got=%b exp=1", i, instr4_valid); end
      tick();
    end
    #2;
    rst4_n = 1'b0;
    #1;
    checks++; if (instr4_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", instr4_valid); end
    checks++; if (instr4 !== 16'h0000) begin failures++; $display("FAIL async_instr got=%h exp=0000", instr4); end
    checks++; if (imem4_addr !== 4'd13) begin failures++; $display("FAIL async_addr got=%h exp=d", imem4_addr); end
    tick();
    rst4_n = 1'b1;
    tick();
    checks++; if (instr4_valid !== 1'b0) begin failures++; $display("FAIL restart_edge1_valid got=%b exp=0", instr4_valid); end
    tick();
    checks++; if (instr4_pc !== 4'd13) begin failures++; $display("FAIL restart_pc got=%h exp=d", instr4_pc); end
    checks++; if (instr4 !== 16'h500D) begin failures++; $display("FAIL restart_instr got=%h exp=500d", instr4); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem10[i] = 16'h4000 | 16'(i);
    for (int i = 0; i < 16; i++) mem4[i] = 16'h5000 | 16'(i);
    rst4_n = 1'b0; stall4 = 1'b0; branch4_en = 1'b0; branch4_target = '0;
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
